dmem_port_arbiter: RTL

Shares the single-ported data memory between the pipeline's execute-stage data port and a secondary DMA/debug master. The pipeline has priority. A starvation counter guarantees the DMA master a grant within a bounded number of cycles. Each read response is tagged and routed back to its requester after the fixed memory latency. The block sits between the execute-stage memory outputs (addr/re/we/store_data) and the data RAM; its stall output ORs into the pipeline stall.

---
 rtl/dmem_port_arbiter_pkg.sv | 25 ++
 rtl/dmem_port_arbiter_if.sv | 57 +++++
 rtl/dmem_port_arbiter_resp_tag_pipe.sv | 41 ++++
 rtl/dmem_port_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_pkg
// Shared types and default constants for the data-memory port arbiter:
//   owner_t     - which requester a memory access belongs to
//   resp_tag_t  - {valid, owner} tag carried alongside an in-flight read
//   DEF_*       - default parameter values for the arbiter and its interface
// -----------------------------------------------------------------------------
package dmem_port_arbiter_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   typedef struct packed {
      logic   valid;
      owner_t owner;
   } resp_tag_t;

   localparam int DEF_ADDR_W   = 32;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_MAX_WAIT = 8;
   localparam int DEF_MEM_LAT  = 2;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Bundles the three buses that meet at the arbiter:
//   cpu_*  - execute-stage data port (request in, stall/read data out)
//   dma_*  - DMA/debug master valid/ready request and read data
//   mem_*  - single-ported data RAM
// Modports:
//   slave  - the arbiter itself
//   master - the environment (pipeline, DMA master and RAM together)
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic              cpu_re;
   logic [BE_W-1:0]   cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_stall;
   logic              cpu_rvalid;
   logic [DATA_W-1:0] cpu_rdata;

   logic              dma_valid;
   logic              dma_ready;
   logic [BE_W-1:0]   dma_we;
   logic [ADDR_W-1:0] dma_addr;
   logic [DATA_W-1:0] dma_wdata;
   logic              dma_rvalid;
   logic [DATA_W-1:0] dma_rdata;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic [BE_W-1:0]   mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_re, cpu_we, cpu_addr, cpu_wdata,
      input  dma_valid, dma_we, dma_addr, dma_wdata,
      input  mem_rdata,
      output cpu_stall, cpu_rvalid, cpu_rdata,
      output dma_ready, dma_rvalid, dma_rdata,
      output mem_addr, mem_re, mem_we, mem_wdata
   );

   modport master (
      output cpu_re, cpu_we, cpu_addr, cpu_wdata,
      output dma_valid, dma_we, dma_addr, dma_wdata,
      output mem_rdata,
      input  cpu_stall, cpu_rvalid, cpu_rdata,
      input  dma_ready, dma_rvalid, dma_rdata,
      input  mem_addr, mem_re, mem_we, mem_wdata
   );

endinterface

// File: rtl/dmem_port_arbiter_resp_tag_pipe.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_resp_tag_pipe
// MEM_LAT-deep shift register of response tags, aligned with the RAM read
// latency so the last stage names the owner of the data on mem_rdata.
// Ports:
//   clk, rst  - clock, synchronous active-high clear (invalidates all stages)
//   clk_en    - stages advance only when high, otherwise hold
//   tag_in    - tag of the access granted this cycle
//   tag_out   - tag whose read data is on mem_rdata this cycle
// -----------------------------------------------------------------------------
module dmem_port_arbiter_resp_tag_pipe
   import dmem_port_arbiter_pkg::*;
#(
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clk_en,
   input  resp_tag_t tag_in,
   output resp_tag_t tag_out
);

   resp_tag_t [MEM_LAT-1:0] stage_r;

   // Tag shift register: one stage per enabled cycle, cleared by reset
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            stage_r[i] <= '{valid: 1'b0, owner: OWN_CPU};
         end
      end else if (clk_en) begin
         stage_r[0] <= tag_in;
         for (int i = 1; i < MEM_LAT; i++) begin
            stage_r[i] <= stage_r[i-1];
         end
      end
   end

   assign tag_out = stage_r[MEM_LAT-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares the single-ported data RAM between the execute-stage data port and a
// DMA/debug master. The pipeline has priority; a saturating starvation counter
// forces a pending DMA request through once it has been refused MAX_WAIT
// cycles. Read responses are tagged and routed back after MEM_LAT cycles.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   clk_en  - global clock enable; all state frozen and no grants when low
//   bus     - dmem_port_arbiter_if.slave (cpu_*, dma_*, mem_* buses)
// -----------------------------------------------------------------------------
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_WAIT = DEF_MAX_WAIT,
   parameter int MEM_LAT  = DEF_MEM_LAT
) (
   input logic                clk,
   input logic                rst,
   input logic                clk_en,
   dmem_port_arbiter_if.slave bus
);

   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   logic              active_s;
   logic              cpu_req_s;
   logic              dma_read_s;
   logic              dma_grant_s;
   logic              cpu_grant_s;
   logic              granted_read_s;
   logic [ADDR_W-1:0] mem_addr_s;
   logic              mem_re_s;
   logic [BE_W-1:0]   mem_we_s;
   logic [DATA_W-1:0] mem_wdata_s;
   logic              cpu_stall_s;
   logic              cpu_rvalid_s;
   logic              dma_rvalid_s;
   logic [CNT_W-1:0]  wait_cnt_r;
   resp_tag_t         tag_in_s;
   resp_tag_t         tag_out_s;

   // Grant decision and memory-port mux; nothing is granted in reset or while frozen
   always_comb begin
      active_s       = clk_en & ~rst;
      cpu_req_s      = bus.cpu_re | (|bus.cpu_we);
      dma_read_s     = (bus.dma_we == {BE_W{1'b0}});
      dma_grant_s    = 1'b0;
      cpu_grant_s    = 1'b0;
      mem_addr_s     = bus.cpu_addr;
      mem_re_s       = 1'b0;
      mem_we_s       = {BE_W{1'b0}};
      mem_wdata_s    = bus.cpu_wdata;
      granted_read_s = 1'b0;

      // DMA wins when the pipeline is idle or the DMA has waited its limit
      if (active_s && bus.dma_valid && (!cpu_req_s || (wait_cnt_r == MAX_WAIT_C))) begin
         dma_grant_s = 1'b1;
      end else if (active_s && cpu_req_s) begin
         cpu_grant_s = 1'b1;
      end else begin
         dma_grant_s = 1'b0;
         cpu_grant_s = 1'b0;
      end

      if (dma_grant_s) begin
         mem_addr_s     = bus.dma_addr;
         mem_re_s       = dma_read_s;
         mem_we_s       = bus.dma_we;
         mem_wdata_s    = bus.dma_wdata;
         granted_read_s = dma_read_s;
      end else if (cpu_grant_s) begin
         mem_addr_s     = bus.cpu_addr;
         mem_re_s       = bus.cpu_re;
         mem_we_s       = bus.cpu_we;
         mem_wdata_s    = bus.cpu_wdata;
         granted_read_s = bus.cpu_re;
      end else begin
         mem_re_s       = 1'b0;
         mem_we_s       = {BE_W{1'b0}};
         granted_read_s = 1'b0;
      end

      cpu_stall_s    = active_s & cpu_req_s & ~cpu_grant_s;
      tag_in_s.valid = granted_read_s;
      tag_in_s.owner = dma_grant_s ? OWN_DMA : OWN_CPU;
   end

   // Starvation counter: counts consecutive refused DMA cycles, saturating at MAX_WAIT
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt_r <= {CNT_W{1'b0}};
      end else if (clk_en) begin
         if (bus.dma_valid && !dma_grant_s) begin
            if (wait_cnt_r != MAX_WAIT_C) begin
               wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end
         end else begin
            wait_cnt_r <= {CNT_W{1'b0}};
         end
      end
   end

   dmem_port_arbiter_resp_tag_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_resp_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .clk_en  (clk_en),
      .tag_in  (tag_in_s),
      .tag_out (tag_out_s)
   );

   // Response routing; while frozen the held last-stage tag stays visible
   always_comb begin
      cpu_rvalid_s = ~rst & tag_out_s.valid & (tag_out_s.owner == OWN_CPU);
      dma_rvalid_s = ~rst & tag_out_s.valid & (tag_out_s.owner == OWN_DMA);
   end

   assign bus.mem_addr   = mem_addr_s;
   assign bus.mem_re     = mem_re_s;
   assign bus.mem_we     = mem_we_s;
   assign bus.mem_wdata  = mem_wdata_s;
   assign bus.dma_ready  = dma_grant_s;
   assign bus.cpu_stall  = cpu_stall_s;
   assign bus.cpu_rvalid = cpu_rvalid_s;
   assign bus.dma_rvalid = dma_rvalid_s;
   assign bus.cpu_rdata  = bus.mem_rdata;
   assign bus.dma_rdata  = bus.mem_rdata;

endmodule
